coalescing_write_buffer: RTL and testbench
==========================================

COALESCING_WRITE_BUFFER -- requirements
Module: coalescing_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; SHALL be a power of two, 2..32.
REQ-002 Parameter ADDR_W, default `MEM_ADDR_SIZE, address width in bits.
REQ-003 Parameter DATA_W, default `WORD_SIZE_BIT, data width in bits.
REQ-004 Parameter COALESCE, default 1; 1 merges a write into an existing pending entry with the same address, 0 always appends.
REQ-005 Port list (name direction width meaning):
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- wr_valid  in  1  cache write-back request
- wr_addr  in  ADDR_W  write-back address
- wr_data  in  DATA_W  write-back data
- wr_ready  out  1  request accepted this cycle
- rd_req  in  1  cache read lookup
- rd_addr  in  ADDR_W  lookup address
- rd_hit  out  1  lookup matched a pending entry
- rd_data  out  DATA_W  data of matched entry
- send  out  1  one-cycle start pulse to sender
- out_addr  out  ADDR_W  head entry address
- out_data  out  DATA_W  head entry data
- out_write  out  1  write qualifier to sender
- done  in  1  one-cycle sender completion pulse
- full, empty  out  1  occupancy flags
- count  out  $clog2(DEPTH)+1  valid entries

Function
REQ-006 Storage SHALL be a circular FIFO: head and tail pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0; full = (count==DEPTH), empty = (count==0).
REQ-007 Match SHALL compare wr_addr and rd_addr against all valid entries combinationally, using registered state only.
REQ-008 Coalesce: COALESCE=1, wr_valid=1, matching valid entry exists and is not the in-flight head -> overwrite that entry's data at the clock edge, count unchanged, wr_ready=1, including when full.
REQ-009 Append: otherwise, wr_valid=1 and !full -> write at tail, tail+1, count+1, wr_ready=1; wr_valid=1 and full -> wr_ready=0, no state change.
REQ-010 A pop in the same cycle SHALL NOT free a slot for an append that cycle (no full bypass).
REQ-011 rd_hit = rd_req and a match; rd_data SHALL be the youngest matching entry (in-flight head included), zero when no hit; a same-cycle wr_valid to rd_addr SHALL NOT be forwarded.
REQ-012 Drain FSM states IDLE, WAIT_DONE:
- IDLE and !empty -> send=1 for one cycle, out_write=1, go WAIT_DONE.
- WAIT_DONE: out_addr/out_data/out_write held stable; done=1 -> pop head, head+1, count-1, out_write=0, go IDLE.
- done=1 in IDLE SHALL be ignored.
REQ-013 Append and pop in the same cycle SHALL leave count unchanged.
REQ-014 With COALESCE=1 at most one non-in-flight entry per address SHALL exist; a write matching only the in-flight head SHALL append.
REQ-015 Minimum drain spacing SHALL be one idle cycle between done and the next send.

Reset
REQ-016 reset=0 at a clock edge SHALL clear all valid bits, head, tail, count; FSM to IDLE.
REQ-017 Reset values: wr_ready=0, rd_hit=0, rd_data=0, send=0, out_addr=0, out_data=0, out_write=0, full=0, empty=1, count=0.
REQ-018 Reset during WAIT_DONE SHALL abandon the in-flight entry; a later done SHALL be ignored.

Structure
REQ-019 ADDR/data width macros SHALL come from sys_defs.vh; FSM state encodings SHALL be local parameters.
REQ-020 The address-match array SHALL be one sub-module, cwb_match, returning per-entry hit vector and youngest-hit index.

Verification
REQ-021 Fill: 4 appends addr 0x10,0x14,0x18,0x1C, done held 0 -> full=1, count=4, 5th write to 0x20 gets wr_ready=0.
REQ-022 Coalesce: pending 0x14=0xAAAA, write 0x14=0xBBBB while full -> wr_ready=1, count unchanged, drained value 0xBBBB.
REQ-023 In-flight: head 0x10 in WAIT_DONE, write 0x10=0x5 -> appended, count+1; rd 0x10 returns 0x5.
REQ-024 Drain: 3 entries, done pulsed 2 cycles after each send -> three sends in order, count 3->0, empty=1.
REQ-025 Wrap: DEPTH=4, 6 writes interleaved with drains -> tail wraps, order and data preserved.
REQ-026 Reset in WAIT_DONE, then done=1 -> no pop, count=0, send stays 0.

Source files
------------

// File: rtl/coalescing_write_buffer_pkg.sv
// Shared constants and helpers for the coalescing write buffer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.

// Width macros normally come from sys_defs.vh; these fallbacks keep the slice
// self-contained when that header is not part of the build.
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif
`ifndef WORD_SIZE_BIT
`define WORD_SIZE_BIT 32
`endif

package coalescing_write_buffer_pkg;

  localparam int CWB_DEPTH_MIN = 2;
  localparam int CWB_DEPTH_MAX = 32;

  // Pointer/index width for a given entry count; never narrower than one bit.
  function automatic int cwb_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cwb_match.sv
// Address-match array: compares one key against every valid entry.
// Latency: purely combinational from registered entry state.
// Backpressure: none; result is valid every cycle.
module cwb_match
  import coalescing_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = cwb_idx_w(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr_i,
  input  logic [IDX_W-1:0]             head_i,
  input  logic [ADDR_W-1:0]            key_i,
  output logic [DEPTH-1:0]             hit_o,
  output logic [IDX_W-1:0]             idx_o
);

  logic [IDX_W-1:0] pos;

  // Per-entry compare, qualified by the entry valid bit
  always_comb begin
    hit_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_o[i] = valid_i[i] && (addr_i[i] == key_i);
    end
  end

  // Walk from the head (oldest) towards the tail; the last hit seen is the youngest
  always_comb begin
    idx_o = '0;
    pos   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = head_i + IDX_W'(k);
      if (hit_o[pos]) begin
        idx_o = pos;
      end
    end
  end

endmodule

// File: rtl/coalescing_write_buffer.sv
// Coalescing write-back buffer: circular FIFO of address/data entries drained one at a time.
// Latency: accepted write is launched (send) two cycles later when the buffer was empty.
// Backpressure: wr_ready low when full and the write cannot merge into a pending entry.
module coalescing_write_buffer
  import coalescing_write_buffer_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = `MEM_ADDR_SIZE,
  parameter int DATA_W   = `WORD_SIZE_BIT,
  parameter int COALESCE = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_valid,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    wr_ready,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_hit,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    send,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_write,
  input  logic                    done,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int IDX_W = cwb_idx_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic ST_IDLE      = 1'b0;
  localparam logic ST_WAIT_DONE = 1'b1;

  // Entry storage and FIFO bookkeeping
  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [IDX_W-1:0]             head_q;
  logic [IDX_W-1:0]             tail_q;
  logic [CNT_W-1:0]             count_q;

  // Drain FSM and registered sender-facing outputs
  logic              state_q, state_d;
  logic              send_q, send_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_write_q, out_write_d;

  // Match results
  logic [DEPTH-1:0] wr_hit_vec;
  logic [IDX_W-1:0] wr_idx;
  logic [DEPTH-1:0] rd_hit_vec;
  logic [IDX_W-1:0] rd_idx;

  logic             full_w;
  logic             empty_w;
  logic             launch;
  logic             head_busy;
  logic             pop;
  logic [DEPTH-1:0] head_oh;
  logic             other_hit;
  logic             do_coal;
  logic             do_app;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  // The head is launched in the cycle the FSM sees it in IDLE; from that
  // moment until done it is treated as in flight and never merged into, so
  // the latched out_data always matches what is finally popped.
  assign launch    = (state_q == ST_IDLE) && !empty_w;
  assign head_busy = (state_q == ST_WAIT_DONE) || launch;
  assign pop       = (state_q == ST_WAIT_DONE) && done;

  cwb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_wr_match (
    .valid_i (valid_q),
    .addr_i  (addr_q),
    .head_i  (head_q),
    .key_i   (wr_addr),
    .hit_o   (wr_hit_vec),
    .idx_o   (wr_idx)
  );

  cwb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_rd_match (
    .valid_i (valid_q),
    .addr_i  (addr_q),
    .head_i  (head_q),
    .key_i   (rd_addr),
    .hit_o   (rd_hit_vec),
    .idx_o   (rd_idx)
  );

  // Mask out the in-flight head so a write matching only it falls through to append
  always_comb begin
    head_oh = '0;
    if (head_busy) begin
      head_oh[head_q] = 1'b1;
    end
    other_hit = |(wr_hit_vec & ~head_oh);
  end

  // Write decision: merge beats append and is allowed even when full; a
  // same-cycle pop never opens a slot for an append
  always_comb begin
    do_coal = wr_valid && (COALESCE != 0) && other_hit;
    do_app  = wr_valid && !do_coal && !full_w;
  end

  // Entry valid bits, pointers and occupancy
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_app) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + IDX_W'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + IDX_W'(1);
      end
      count_q <= count_q + CNT_W'(do_app) - CNT_W'(pop);
    end
  end

  // Entry payload; contents of invalid slots are don't-care so no reset needed
  always_ff @(posedge clock) begin
    if (reset && do_app) begin
      addr_q[tail_q] <= wr_addr;
      data_q[tail_q] <= wr_data;
    end else if (reset && do_coal) begin
      data_q[wr_idx] <= wr_data;
    end
  end

  // Drain FSM state register together with the sender-facing output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      send_q      <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      send_q      <= send_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_write_q <= out_write_d;
    end
  end

  // Drain FSM next state; done outside WAIT_DONE is ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!empty_w) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (done)     state_d = ST_IDLE;
    endcase
  end

  // Drain FSM outputs: latch the head on launch, hold through WAIT_DONE, clear on pop.
  // Registering send gives the required idle cycle between done and the next send.
  always_comb begin
    send_d      = 1'b0;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_write_d = out_write_q;
    if (launch) begin
      send_d      = 1'b1;
      out_addr_d  = addr_q[head_q];
      out_data_d  = data_q[head_q];
      out_write_d = 1'b1;
    end else if (pop) begin
      out_addr_d  = '0;
      out_data_d  = '0;
      out_write_d = 1'b0;
    end
  end

  // Lookup: youngest matching entry, head included; the write port is never forwarded
  always_comb begin
    rd_hit  = rd_req && (|rd_hit_vec);
    rd_data = rd_hit ? data_q[rd_idx] : '0;
  end

  assign wr_ready  = reset && (do_coal || do_app);
  assign send      = send_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_write = out_write_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign count     = count_q;

endmodule

// File: tb/tb_coalescing_write_buffer.sv
// Directed bench for the coalescing write buffer with a drain scoreboard.
// Latency: n/a.
// Backpressure: sender model pulses done two cycles after each send when enabled.
module tb_coalescing_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = `MEM_ADDR_SIZE;
  localparam int DW    = `WORD_SIZE_BIT;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } drain_t;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   wr_valid = 1'b0;
  logic [AW-1:0]          wr_addr = '0;
  logic [DW-1:0]          wr_data = '0;
  logic                   wr_ready;
  logic                   rd_req = 1'b0;
  logic [AW-1:0]          rd_addr = '0;
  logic                   rd_hit;
  logic [DW-1:0]          rd_data;
  logic                   send;
  logic [AW-1:0]          out_addr;
  logic [DW-1:0]          out_data;
  logic                   out_write;
  logic                   done;
  logic                   done_auto = 1'b0;
  logic                   done_man = 1'b0;
  logic                   auto_done = 1'b0;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int failures = 0;
  drain_t exp_q[$];

  assign done = done_auto | done_man;

  always #5 clock = ~clock;

  coalescing_write_buffer #(
    .DEPTH    (DEPTH),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .COALESCE (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data),
    .send      (send),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_write (out_write),
    .done      (done),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic exp_rdy, input string nm);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clock);
    chk(nm, 32'(wr_ready), 32'(exp_rdy));
    @(posedge clock);
    #1 wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic eh, input logic [DW-1:0] ed, input string nm);
    rd_req  = 1'b1;
    rd_addr = a;
    @(negedge clock);
    chk({nm, "_hit"}, 32'(rd_hit), 32'(eh));
    chk({nm, "_data"}, 32'(rd_data), 32'(ed));
    @(posedge clock);
    #1 rd_req = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_empty(input int budget, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (empty) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for empty count=%0d", nm, count);
    end
    tick();
  endtask

  task automatic wait_send(input int budget, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (send) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for send", nm);
    end
    tick();
  endtask

  // Scoreboard monitor: every send must match the next expected drained entry
  initial begin
    drain_t e;
    forever begin
      @(negedge clock);
      if (reset && send) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_send addr=0x%0h data=0x%0h expected no send", out_addr, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("drain_addr", 32'(out_addr), 32'(e.addr));
          chk("drain_data", 32'(out_data), 32'(e.data));
          chk("drain_write", 32'(out_write), 32'd1);
        end
      end
    end
  end

  // Sender model: done two cycles after send
  initial begin
    forever begin
      @(negedge clock);
      if (send && auto_done) begin
        repeat (2) @(posedge clock);
        #1 done_auto = 1'b1;
        @(posedge clock);
        #1 done_auto = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    // Reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_hit", 32'(rd_hit), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_send", 32'(send), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_write", 32'(out_write), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;

    // Fill with done held low; 0x10 launches and stays in flight
    exp_q.push_back('{addr: AW'(32'h10), data: DW'(32'h1)});
    wr(AW'(32'h10), DW'(32'h1), 1'b1, "fill_wr0");
    wr(AW'(32'h14), DW'(32'hAAAA), 1'b1, "fill_wr1");
    wr(AW'(32'h18), DW'(32'h3), 1'b1, "fill_wr2");
    wr(AW'(32'h1C), DW'(32'h4), 1'b1, "fill_wr3");
    @(negedge clock);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_full", 32'(full), 32'd1);
    tick();
    wr(AW'(32'h20), DW'(32'h5), 1'b0, "fill_reject");
    @(negedge clock);
    chk("reject_count", 32'(count), 32'd4);
    tick();

    // Coalesce into pending 0x14 while full
    wr(AW'(32'h14), DW'(32'hBBBB), 1'b1, "coal_ready");
    @(negedge clock);
    chk("coal_count", 32'(count), 32'd4);
    tick();
    rd(AW'(32'h14), 1'b1, DW'(32'hBBBB), "rd_coal");
    rd(AW'(32'h20), 1'b0, DW'(32'h0), "rd_miss");

    // Release the in-flight head and drain the rest automatically
    exp_q.push_back('{addr: AW'(32'h14), data: DW'(32'hBBBB)});
    exp_q.push_back('{addr: AW'(32'h18), data: DW'(32'h3)});
    exp_q.push_back('{addr: AW'(32'h1C), data: DW'(32'h4)});
    auto_done = 1'b1;
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    wait_empty(200, "drain_fill");
    repeat (3) tick();
    chk("drain_fill_all", 32'(exp_q.size()), 32'd0);

    // Three entries drained in order, count 3 -> 0
    exp_q.push_back('{addr: AW'(32'h30), data: DW'(32'h11)});
    exp_q.push_back('{addr: AW'(32'h34), data: DW'(32'h22)});
    exp_q.push_back('{addr: AW'(32'h38), data: DW'(32'h33)});
    wr(AW'(32'h30), DW'(32'h11), 1'b1, "drain_wr0");
    wr(AW'(32'h34), DW'(32'h22), 1'b1, "drain_wr1");
    wr(AW'(32'h38), DW'(32'h33), 1'b1, "drain_wr2");
    @(negedge clock);
    chk("drain_count3", 32'(count), 32'd3);
    tick();
    wait_empty(200, "drain3");
    repeat (3) tick();
    chk("drain3_count", 32'(count), 32'd0);
    chk("drain3_empty", 32'(empty), 32'd1);
    chk("drain3_all", 32'(exp_q.size()), 32'd0);

    // Wrap: six writes interleaved with drains
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{addr: AW'(32'h40 + 4 * i), data: DW'(32'h100 + i)});
      wr(AW'(32'h40 + 4 * i), DW'(32'h100 + i), 1'b1, "wrap_wr");
      repeat (3) tick();
    end
    wait_empty(300, "wrap");
    repeat (3) tick();
    chk("wrap_all", 32'(exp_q.size()), 32'd0);

    // In-flight head is not merged into; later reset abandons it
    auto_done = 1'b0;
    exp_q.push_back('{addr: AW'(32'h10), data: DW'(32'h1)});
    wr(AW'(32'h10), DW'(32'h1), 1'b1, "inflight_base");
    wait_send(20, "inflight_send");
    wr(AW'(32'h10), DW'(32'h5), 1'b1, "inflight_append");
    @(negedge clock);
    chk("inflight_count", 32'(count), 32'd2);
    tick();
    rd(AW'(32'h10), 1'b1, DW'(32'h5), "rd_inflight");

    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clock);
    chk("rstwait_count", 32'(count), 32'd0);
    chk("rstwait_empty", 32'(empty), 32'd1);
    chk("rstwait_out_write", 32'(out_write), 32'd0);
    tick();
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (send) seen = 1'b1;
    end
    chk("rstwait_no_send", 32'(seen), 32'd0);
    chk("rstwait_count_after_done", 32'(count), 32'd0);
    chk("all_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
